alarm_controller: RTL
=====================

Name: alarm_controller

Overview:
- Downstream consumer of the kitchen timer's status and time outputs (`led`, `min_out`, `sec_out`, `enable`).
- Generates the audible alarm, blink pattern and pre-expiry warning chirp that the bare status LED cannot provide.
- Handles user acknowledge and snooze, with an automatic ring timeout.
- Runs on the 100 MHz board clock beside the display driver.

Parameters:
- TONE_HALF, 25000, clk cycles per half-period of the buzzer square wave (2 kHz at 100 MHz).
- BEAT_DIV, 25000000, clk cycles per beat (0.25 s); all pattern timing is counted in beats.
- RING_BEATS, 120, beats of ringing before auto-stop (30 s).
- SNOOZE_BEATS, 240, beats of silence in snooze before re-ring (60 s).
- WARN_SECS, 10, warning window; warn is active while the time is 00:01..00:WARN_SECS when counting down.

Ports:
- clk  in  1  100 MHz board clock.
- rst  in  1  Reset: one clock domain; reset is synchronous and active-low (low = reset, sampled on the clk rising edge).
- done  in  1  Timer expired level (the timer's `led`).
- enable  in  1  Count direction: 0 = down, 1 = up.
- min_in  in  6  Current minutes, binary 0..59.
- sec_in  in  6  Current seconds, binary 0..59.
- ack_btn  in  1  Debounced acknowledge level.
- snooze_btn  in  1  Debounced snooze level.
- buzzer  out  1  Tone drive to the piezo.
- alarm_led  out  1  Blink/solid alarm indicator.
- missed  out  1  Sticky flag: an alarm timed out unacknowledged.
- ringing  out  1  High while in RING.

Behaviour:
- Reset (rst == 0): state = IDLE, all counters = 0, buzzer/alarm_led/missed/ringing = 0. Reset mid-ring silences on the next edge.
- Edge detection: done, ack_btn and snooze_btn are each registered once; rise = current & ~previous. Held buttons act only once.
- tone_sq: a free-running counter toggles tone_sq every TONE_HALF cycles.
- beat_stb: one-cycle pulse every BEAT_DIV cycles.
- beat_cnt: counts beat_stb; cleared on every state entry. It saturates at its terminal value and never wraps mid-state.
- Outputs are registered. buzzer = tone_sq & tone_en, and is valid one cycle after the state or beat change that drives it.
- IDLE:
  - Enter RING on done rise.
  - Else enter WARN if enable == 0, done == 0, min_in == 0 and 1 <= sec_in <= WARN_SECS.
  - Outputs: tone_en = 0, alarm_led = 0.
- WARN:
  - tone_en = 1 only while beat_cnt[1:0] == 0, giving one chirp per second.
  - Return to IDLE on leaving the window: enable == 1, min_in != 0, or sec_in > WARN_SECS.
  - done rise goes to RING; this takes priority over the window check.
- RING:
  - Pattern: ringing = 1, tone_en = ~beat_cnt[0], alarm_led = ~beat_cnt[0] (0.25 s on/off).
  - Exit priority, highest first:
    1. done == 0 (timer reset/reloaded) -> IDLE.
    2. ack rise -> IDLE; clears missed.
    3. snooze rise -> SNOOZE.
    4. beat_cnt reaches RING_BEATS -> IDLE; sets missed.
  - ack and snooze in the same cycle: ack wins.
- SNOOZE:
  - Outputs: tone_en = 0, alarm_led = 1 (solid).
  - done == 0 or ack rise -> IDLE.
  - beat_cnt reaches SNOOZE_BEATS -> RING with beat_cnt restarted.
  - Further snooze rises are ignored.
- Re-arm: RING is entered only from a done rise, or from a snooze expiry. After ack with done still high, the block stays IDLE.
- missed:
  - Set on RING timeout.
  - Cleared by ack rise in any state, or by reset.
  - A set and a clear in the same cycle resolve as clear.
- Arithmetic: beat_cnt width = clog2(max(RING_BEATS, SNOOZE_BEATS) + 1). All time comparisons are unsigned 6-bit.

Decomposition:
- Shared package alarm_pkg holds:
  - state enumeration: IDLE, WARN, RING, SNOOZE (2-bit);
  - default parameter constants;
  - the clog2 helper function.
- One sub-module, tone_beat_gen: holds the tone prescaler and beat prescaler, and outputs tone_sq and beat_stb. It shares clk and rst; counters reset to 0.

Test Plan:
Bench parameters: TONE_HALF = 4, BEAT_DIV = 20, RING_BEATS = 8, SNOOZE_BEATS = 6, WARN_SECS = 10.
- Reset/ring: hold rst low for 3 cycles, then raise done.
  - Next cycle: ringing = 1.
  - buzzer toggles every 4 cycles during even beats and stays 0 during odd beats.
  - alarm_led is high 20 cycles, low 20 cycles.
- Timeout: leave done high with no buttons. After 8 beats (160 cycles): state = IDLE, ringing = 0, missed = 1, buzzer = 0. No re-ring while done stays high.
- Snooze cycle: in RING, pulse snooze.
  - Result: buzzer = 0, alarm_led = 1 for 6 beats (120 cycles), then RING resumes with beat 0.
  - Then pulse ack: IDLE, missed = 0.
- Simultaneous: assert ack and snooze on the same cycle in RING -> IDLE, not SNOOZE.
  - Holding both buttons afterwards produces no further transitions.
- Warning: enable = 0, min = 0, sweep sec from 12 down to 1.
  - No chirp at sec = 11.
  - At sec <= 10: buzzer active 1 beat in 4.
  - Setting enable = 1 returns to IDLE next cycle.
- Mid-operation aborts:
  - Drop done while in RING -> IDLE next cycle, buzzer = 0.
  - Assert rst low during SNOOZE -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared state encoding, default timing constants and width helper for the alarm controller.
// Declarations only: no latency, no backpressure.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARN   = 2'd1,
        RING   = 2'd2,
        SNOOZE = 2'd3
    } alarm_state_t;

    localparam int TONE_HALF_DEF    = 25000;
    localparam int BEAT_DIV_DEF     = 25000000;
    localparam int RING_BEATS_DEF   = 120;
    localparam int SNOOZE_BEATS_DEF = 240;
    localparam int WARN_SECS_DEF    = 10;

    // Smallest width whose range 0..2**w-1 covers value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tone_beat_gen.sv
// Buzzer square-wave and beat-strobe prescalers; tone_sq registered, beat_stb decoded from the count.
// Free-running, no backpressure; beat_restart realigns the beat phase to a state entry.
module tone_beat_gen
    import alarm_pkg::*;
#(
    parameter int TONE_HALF = TONE_HALF_DEF,
    parameter int BEAT_DIV  = BEAT_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic beat_restart,
    output logic tone_sq,
    output logic beat_stb
);

    localparam int TW = clog2(TONE_HALF + 1);
    localparam int BW = clog2(BEAT_DIV + 1);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);

    logic [TW-1:0] tone_cnt;
    logic [BW-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tone_cnt <= '0;
            tone_sq  <= 1'b0;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone_sq  <= ~tone_sq;
        end else begin
            tone_cnt <= tone_cnt + TW'(1);
        end
    end

    // Restarting on state entry makes every beat in a state a full BEAT_DIV long.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (beat_restart || (div_cnt == BEAT_LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + BW'(1);
        end
    end

    assign beat_stb = (div_cnt == BEAT_LAST);

endmodule

// File: rtl/alarm_controller.sv
// Kitchen-timer alarm: warning chirp, ring pattern, snooze and ack with timeout and missed flag.
// Outputs registered one cycle after the state/beat that drives them; no backpressure.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int TONE_HALF    = TONE_HALF_DEF,
    parameter int BEAT_DIV     = BEAT_DIV_DEF,
    parameter int RING_BEATS   = RING_BEATS_DEF,
    parameter int SNOOZE_BEATS = SNOOZE_BEATS_DEF,
    parameter int WARN_SECS    = WARN_SECS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic       enable,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    input  logic       ack_btn,
    input  logic       snooze_btn,
    output logic       buzzer,
    output logic       alarm_led,
    output logic       missed,
    output logic       ringing
);

    localparam int MAX_BEATS = (RING_BEATS > SNOOZE_BEATS) ? RING_BEATS : SNOOZE_BEATS;
    localparam int CW = clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] CNT_SAT     = '1;
    localparam logic [CW-1:0] RING_LAST   = CW'(RING_BEATS);
    localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_BEATS);
    localparam logic [5:0]    WARN_LIMIT  = 6'(WARN_SECS);

    alarm_state_t  state;
    alarm_state_t  state_nxt;
    logic [CW-1:0] beat_cnt;
    logic          done_q;
    logic          ack_q;
    logic          snooze_q;
    logic          done_rise;
    logic          ack_rise;
    logic          snooze_rise;
    logic          in_window;
    logic          window_left;
    logic          timeout_hit;
    logic          state_change;
    logic          tone_en;
    logic          led_nxt;
    logic          ring_nxt;
    logic          tone_sq;
    logic          beat_stb;

    tone_beat_gen #(
        .TONE_HALF (TONE_HALF),
        .BEAT_DIV  (BEAT_DIV)
    ) u_tone_beat_gen (
        .clk          (clk),
        .rst          (rst),
        .beat_restart (state_change),
        .tone_sq      (tone_sq),
        .beat_stb     (beat_stb)
    );

    assign done_rise   = done & ~done_q;
    assign ack_rise    = ack_btn & ~ack_q;
    assign snooze_rise = snooze_btn & ~snooze_q;

    assign in_window   = !enable && (min_in == 6'd0) && (sec_in != 6'd0) && (sec_in <= WARN_LIMIT);
    assign window_left = enable || (min_in != 6'd0) || (sec_in > WARN_LIMIT);

    assign state_change = (state_nxt != state);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (done_rise) begin
                    state_nxt = RING;
                end else if (!done && in_window) begin
                    state_nxt = WARN;
                end
            end
            WARN: begin
                if (done_rise) begin
                    state_nxt = RING;
                end else if (window_left) begin
                    state_nxt = IDLE;
                end
            end
            RING: begin
                // Ack outranks snooze so a simultaneous press lands in IDLE.
                if (!done || ack_rise) begin
                    state_nxt = IDLE;
                end else if (snooze_rise) begin
                    state_nxt = SNOOZE;
                end else if (beat_cnt == RING_LAST) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            SNOOZE: begin
                if (!done || ack_rise) begin
                    state_nxt = IDLE;
                end else if (beat_cnt == SNOOZE_LAST) begin
                    state_nxt = RING;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tone_en  = 1'b0;
        led_nxt  = 1'b0;
        ring_nxt = 1'b0;
        case (state)
            WARN: tone_en = (beat_cnt[1:0] == 2'b00);
            RING: begin
                ring_nxt = 1'b1;
                tone_en  = ~beat_cnt[0];
                led_nxt  = ~beat_cnt[0];
            end
            SNOOZE: led_nxt = 1'b1;
            default: begin
                tone_en  = 1'b0;
                led_nxt  = 1'b0;
                ring_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            snooze_q  <= 1'b0;
            beat_cnt  <= '0;
            buzzer    <= 1'b0;
            alarm_led <= 1'b0;
            ringing   <= 1'b0;
            missed    <= 1'b0;
        end else begin
            done_q   <= done;
            ack_q    <= ack_btn;
            snooze_q <= snooze_btn;

            if (state_change) begin
                beat_cnt <= '0;
            end else if (beat_stb && (beat_cnt != CNT_SAT)) begin
                beat_cnt <= beat_cnt + CW'(1);
            end

            buzzer    <= tone_sq & tone_en;
            alarm_led <= led_nxt;
            ringing   <= ring_nxt;

            if (ack_rise) begin
                missed <= 1'b0;
            end else if (timeout_hit) begin
                missed <= 1'b1;
            end
        end
    end

endmodule
